// File: rtl/jtshouse_cus116_pkg.sv
// Shared types and constants for the CUS116 raster window / IRQ consumer.
package jtshouse_cus116_pkg;

    localparam int COORD_W     = 9;
    localparam int DEFAULT_DLY = 2;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } irq_state_t;

endpackage

// File: rtl/jtshouse_cus116_dly.sv
// 1-bit shift register with clock enable; N=0 degenerates to a wire.
module jtshouse_cus116_dly #(
    parameter int N = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic d,
    output logic q
);

    generate
        if (N == 0) begin : g_pass
            assign q = d;
        end else begin : g_sr
            logic [N-1:0] sr;

            // NOTE: the stages are plain flops, so clearing them on reset is
            // cheap and keeps a stale window from leaking out after reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else if (cen) begin
                    sr[0] <= d;
                    for (int i = 1; i < N; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[N-1];
        end
    endgenerate

endmodule

// File: rtl/jtshouse_cus116_raster.sv
// CUS116 raster consumer: per-line shadowed clip window and raster IRQ.
// Optional macro JTSHOUSE_CUS116_AUTOCLR_EN adds a pending-IRQ self-clear timer.
module jtshouse_cus116_raster
    import jtshouse_cus116_pkg::*;
#(
    parameter int DLY     = DEFAULT_DLY,
    parameter int AUTOCLR = 64
)(
    input  logic        rst,
    input  logic        clk,
    input  logic        pxl_cen,
    input  logic [8:0]  hdump,
    input  logic [8:0]  vdump,
    input  logic        hs,
    input  logic [8:0]  left,
    input  logic [8:0]  right,
    input  logic [8:0]  top,
    input  logic [8:0]  bottom,
    input  logic [15:0] hirq,
    input  logic [15:0] virq,
    input  logic        irq_en,
    input  logic        irq_ack,
    output logic        win,
    output logic        irq,
    output logic        line_win
);

    logic       hs_l;
    logic       hs_rise;
    coord_t     lsh, rsh, hsh, vsh;
    logic       raw;
    logic       pos_match;
    irq_state_t state;

    // Only the low 9 bits of the IRQ position registers are meaningful.
    logic unused_bits;
    assign unused_bits = ^{hirq[15:9], virq[15:9]};

    assign hs_rise = hs & ~hs_l;

    // NOTE: all state updates use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_l     <= 1'b0;
            lsh      <= '0;
            rsh      <= '0;
            hsh      <= '0;
            vsh      <= '0;
            line_win <= 1'b0;
        end else begin
            hs_l <= hs;
            if (hs_rise) begin
                lsh      <= left;
                rsh      <= right;
                hsh      <= hirq[8:0];
                vsh      <= virq[8:0];
                line_win <= (top <= vdump) && (vdump < bottom);
            end
        end
    end

    // An inverted column range (lsh >= rsh) can never satisfy both compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw <= 1'b0;
        end else if (pxl_cen) begin
            raw <= line_win && (lsh <= hdump) && (hdump < rsh);
        end
    end

    jtshouse_cus116_dly #(
        .N (DLY)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .cen (pxl_cen),
        .d   (raw),
        .q   (win)
    );

    assign pos_match = (hdump == hsh) && (vdump == vsh);

`ifdef JTSHOUSE_CUS116_AUTOCLR_EN
    localparam int AC_W = $clog2(AUTOCLR + 1);
    logic [AC_W-1:0] ac_cnt;
`else
    logic unused_autoclr;
    assign unused_autoclr = ^AUTOCLR;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            irq    <= 1'b0;
`ifdef JTSHOUSE_CUS116_AUTOCLR_EN
            ac_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    irq <= 1'b0;
                    if (irq_en) state <= ARMED;
                end
                ARMED: begin
                    irq <= 1'b0;
                    if (!irq_en) begin
                        state <= IDLE;
                    end else if (pxl_cen && pos_match && !irq_ack) begin
                        // An ack landing on the match pixel swallows the IRQ.
                        state  <= PENDING;
                        irq    <= 1'b1;
`ifdef JTSHOUSE_CUS116_AUTOCLR_EN
                        ac_cnt <= '0;
`endif
                    end
                end
                PENDING: begin
                    if (irq_ack) begin
                        irq   <= 1'b0;
                        state <= irq_en ? ARMED : IDLE;
                    end
`ifdef JTSHOUSE_CUS116_AUTOCLR_EN
                    else if (pxl_cen) begin
                        if (ac_cnt == AC_W'(AUTOCLR - 1)) begin
                            irq   <= 1'b0;
                            state <= ARMED;
                        end else begin
                            ac_cnt <= ac_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtshouse_cus116_raster.sv
// Directed bench for jtshouse_cus116_raster (DLY=2, AUTOCLR=64).
module tb_jtshouse_cus116_raster;

    logic        rst;
    logic        clk;
    logic        pxl_cen;
    logic [8:0]  hdump;
    logic [8:0]  vdump;
    logic        hs;
    logic [8:0]  left;
    logic [8:0]  right;
    logic [8:0]  top;
    logic [8:0]  bottom;
    logic [15:0] hirq;
    logic [15:0] virq;
    logic        irq_en;
    logic        irq_ack;
    logic        win;
    logic        irq;
    logic        line_win;

    int checks = 0;
    int errors = 0;

    jtshouse_cus116_raster #(
        .DLY     (2),
        .AUTOCLR (64)
    ) dut (
        .rst      (rst),
        .clk      (clk),
        .pxl_cen  (pxl_cen),
        .hdump    (hdump),
        .vdump    (vdump),
        .hs       (hs),
        .left     (left),
        .right    (right),
        .top      (top),
        .bottom   (bottom),
        .hirq     (hirq),
        .virq     (virq),
        .irq_en   (irq_en),
        .irq_ack  (irq_ack),
        .win      (win),
        .irq      (irq),
        .line_win (line_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One pixel: hdump is sampled with pxl_cen on the next rising edge.
    task automatic pix(input logic [8:0] h);
        @(negedge clk);
        hdump   = h;
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
    endtask

    task automatic new_line(input logic [8:0] v);
        @(negedge clk);
        vdump = v;
        hs    = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        @(negedge clk);
    endtask

    // win reflects the pixel presented three pixel enables earlier.
    task automatic win_at(input string tag, input logic [8:0] h, input logic exp);
        pix(h);
        pix(9'h000);
        pix(9'h000);
        check(tag, win, exp);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; hdump = '0; vdump = '0; hs = 1'b0;
        left = '0; right = '0; top = '0; bottom = '0;
        hirq = '0; virq = '0; irq_en = 1'b0; irq_ack = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_win", win, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_line_win", line_win, 1'b0);
        rst = 1'b0;

        // Registers programmed but no hs yet: shadows still zero.
        left = 9'h020; right = 9'h120; top = 9'h010; bottom = 9'h0F0;
        vdump = 9'h050;
        win_at("no_hs_win", 9'h050, 1'b0);
        check("no_hs_line_win", line_win, 1'b0);

        // Window inclusion and latency.
        new_line(9'h050);
        check("line_in", line_win, 1'b1);
        pix(9'h000); pix(9'h000); pix(9'h000);
        pix(9'h020);
        check("lat_1", win, 1'b0);
        pix(9'h000);
        check("lat_2", win, 1'b0);
        pix(9'h000);
        check("lat_3", win, 1'b1);
        pix(9'h000);
        check("lat_4", win, 1'b0);
        win_at("h_1f", 9'h01F, 1'b0);
        win_at("h_20", 9'h020, 1'b1);
        win_at("h_11f", 9'h11F, 1'b1);
        win_at("h_120", 9'h120, 1'b0);

        new_line(9'h00F);
        check("line_0f", line_win, 1'b0);
        win_at("v0f_h_11f", 9'h11F, 1'b0);
        new_line(9'h0F0);
        check("line_f0", line_win, 1'b0);
        win_at("vf0_h_11f", 9'h11F, 1'b0);
        new_line(9'h010);
        check("line_10", line_win, 1'b1);

        // Empty (inverted) column range.
        left = 9'h100; right = 9'h080;
        new_line(9'h050);
        check("empty_line_win", line_win, 1'b1);
        win_at("empty_h_7f", 9'h07F, 1'b0);
        win_at("empty_h_90", 9'h090, 1'b0);
        win_at("empty_h_100", 9'h100, 1'b0);

        // Degenerate line range.
        top = 9'h080; bottom = 9'h080;
        new_line(9'h080);
        check("top_eq_bottom", line_win, 1'b0);

        // Mid-line write takes effect on the next line.
        left = 9'h020; right = 9'h120; top = 9'h010; bottom = 9'h0F0;
        new_line(9'h050);
        win_at("mid_before", 9'h020, 1'b1);
        pix(9'h030);
        left = 9'h040;
        win_at("mid_same_20", 9'h020, 1'b1);
        new_line(9'h051);
        win_at("mid_next_20", 9'h020, 1'b0);
        win_at("mid_next_3f", 9'h03F, 1'b0);
        win_at("mid_next_40", 9'h040, 1'b1);

        // IRQ at the programmed position.
        virq = 16'h0080; hirq = 16'h0010; irq_en = 1'b1;
        new_line(9'h080);
        check("irq_armed_low", irq, 1'b0);
        hdump = 9'h010;
        @(negedge clk);
        check("irq_needs_cen", irq, 1'b0);
        pxl_cen = 1'b1;
        @(posedge clk);
        #1;
        check("irq_rise", irq, 1'b1);
        @(negedge clk);
        pxl_cen = 1'b0;
        pix(9'h011);
        check("irq_hold", irq, 1'b1);
        ack_pulse();
        check("irq_acked", irq, 1'b0);
        pix(9'h012);
        check("irq_no_second", irq, 1'b0);
        new_line(9'h081);
        pix(9'h010);
        check("irq_other_line", irq, 1'b0);

        // Ack colliding with the match.
        new_line(9'h080);
        @(negedge clk);
        hdump = 9'h010; pxl_cen = 1'b1; irq_ack = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0; irq_ack = 1'b0;
        check("collide", irq, 1'b0);
        pix(9'h011);
        check("collide_after", irq, 1'b0);

        // irq_en drop while pending.
        new_line(9'h080);
        pix(9'h010);
        check("en_drop_set", irq, 1'b1);
        irq_en = 1'b0;
        repeat (5) @(negedge clk);
        check("en_drop_hold", irq, 1'b1);
        ack_pulse();
        check("en_drop_ack", irq, 1'b0);
        new_line(9'h080);
        pix(9'h010);
        check("idle_no_irq", irq, 1'b0);

        // Self-clear versus indefinite hold.
        irq_en = 1'b1;
        new_line(9'h080);
        pix(9'h010);
        check("ac_set", irq, 1'b1);
`ifdef JTSHOUSE_CUS116_AUTOCLR_EN
        repeat (63) pix(9'h011);
        check("ac_63", irq, 1'b1);
        pix(9'h011);
        check("ac_64", irq, 1'b0);
`else
        repeat (1000) pix(9'h011);
        check("hold_1000", irq, 1'b1);
        ack_pulse();
        check("hold_ack", irq, 1'b0);
`endif

        // Asynchronous reset mid-frame.
        new_line(9'h080);
        pix(9'h010);
        check("pre_rst_irq", irq, 1'b1);
        new_line(9'h050);
        pix(9'h050); pix(9'h050); pix(9'h050);
        check("pre_rst_win", win, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_win", win, 1'b0);
        check("async_line_win", line_win, 1'b0);
        check("async_irq", irq, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        win_at("post_rst_win", 9'h050, 1'b0);
        new_line(9'h050);
        win_at("post_rst_hs_win", 9'h050, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtshouse_cus116_raster.md
Name: jtshouse_cus116_raster

Overview:
- Consumer side of the CUS116 register file: turns the programmed clip window (left/right/top/bottom) and raster IRQ position (hirq/virq) into per-pixel window enables and a CPU raster interrupt.
- Sits between the video timing generator and the sprite/tile mixer; its IRQ output goes to the sub-CPU interrupt controller.
- Register values are shadowed once per line so CPU writes never tear a line.

Parameters:
- DLY, 2, pixel-clock-enable stages applied to the window enable to align it with the mixer pipeline (0..7).
- AUTOCLR, 64, pixel-enable count before a pending IRQ self-clears (used only with the optional feature).

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  system clock; the only clock in the block
- pxl_cen  in  1  pixel clock enable
- hdump  in  9  current horizontal pixel count
- vdump  in  9  current line number
- hs  in  1  horizontal sync, active high
- left  in  9  window start column, inclusive
- right  in  9  window end column, exclusive
- top  in  9  window start line, inclusive
- bottom  in  9  window end line, exclusive
- hirq  in  16  IRQ column; bits [8:0] are used
- virq  in  16  IRQ line; bits [8:0] are used
- irq_en  in  1  raster IRQ enable
- irq_ack  in  1  one-clock CPU acknowledge pulse
- win  out  1  pixel is inside the clip window, delayed by DLY
- irq  out  1  raster IRQ, level, active high
- line_win  out  1  current line lies within [top,bottom)

Behaviour:
- Reset values: win=0, irq=0, line_win=0. All shadow registers are 0, the delay line is cleared, and the IRQ FSM is in IDLE.
- Shadowing:
  - On the rising edge of hs, detected in clk with a 1-cycle registered hs_l, latch left/right/top/bottom/hirq[8:0]/virq[8:0] into shadows.
  - Comparisons use only the shadows. A write mid-line takes effect on the next line.
- line_win:
  - Registered on the same hs edge as (top <= vdump < bottom), using the new shadows.
  - If top >= bottom, line_win=0 for every line.
- Raw window:
  - raw = line_win & (lsh <= hdump) & (hdump < rsh), evaluated on pxl_cen.
  - If lsh >= rsh, raw=0.
  - All compares are 9-bit unsigned with no wrap.
- Window delay:
  - raw passes through DLY registers, each advancing only on pxl_cen.
  - With DLY=0, win is raw registered once on pxl_cen.
  - Total latency from hdump change to win is DLY+1 pixel enables.
- IRQ FSM (advances on clk; match is evaluated on pxl_cen):
  - IDLE: go to ARMED when irq_en=1.
  - ARMED: on pxl_cen with hdump==hsh and vdump==vsh, go to PENDING and set irq=1. If irq_en drops, go to IDLE.
  - PENDING: irq_ack=1 clears irq next clk and goes to ARMED, or to IDLE if irq_en=0. irq_en=0 alone does not clear a pending IRQ.
- Simultaneous match and ack in PENDING: ack wins, irq clears, and the FSM returns to ARMED. The match is not re-taken that frame because the pixel position has already passed.
- A match can occur at most once per frame, since the position repeats only once per frame.
- Reset mid-frame: all state returns to reset values immediately (async). After release the window stays 0 until the next hs edge has loaded the shadows.

Optional Feature:
- Macro: JTSHOUSE_CUS116_AUTOCLR_EN
- Defined: in PENDING, a counter counts pxl_cen pulses. After AUTOCLR pulses without an ack, irq clears and the FSM goes to ARMED. The counter resets on entry to PENDING.
- Undefined: no counter is built, and irq holds until irq_ack or reset.

Decomposition:
- Shared package/include jtshouse_cus116_pkg holds:
  - the FSM state encodings IDLE=2'd0, ARMED=2'd1, PENDING=2'd2;
  - the 9-bit coordinate width constant;
  - the default DLY.
- One sub-module, jtshouse_cus116_dly: a parameterised 1-bit shift register with clock enable and async reset, used for the window delay.

Test Plan:
- Window inclusion: left=0x20, right=0x120, top=0x10, bottom=0xF0, DLY=2, vdump=0x50. win is high for hdump 0x20..0x11F, seen 3 pxl_cen later; it is low for hdump=0x11F on line 0x0F and on line 0xF0.
- Empty window: left=0x100, right=0x80. win stays 0 for the whole frame, and line_win is unaffected.
- Mid-line write: change left from 0x20 to 0x40 while hdump=0x30. The current line keeps the first high at 0x20; the next line's first high is at 0x40.
- IRQ at the programmed position: irq_en=1, virq=0x0080, hirq=0x0010. irq rises one clk after the pxl_cen with v=0x80, h=0x10; irq_ack clears it next clk; no second IRQ occurs until the next frame.
- Ack collides with match, and irq_en drop: an ack in the same cycle as the match leaves irq=0. With irq_en=0 in PENDING, irq holds until the ack and the FSM then goes to IDLE.
- Auto-clear: with JTSHOUSE_CUS116_AUTOCLR_EN and AUTOCLR=64, irq drops after exactly 64 pxl_cen with no ack. Without the macro, irq is still high after 1000 pxl_cen.
